// File: rtl/programmable_gate_pkg.sv
// Shared constants for the programmable gate pipeline: function codes and their width.
package programmable_gate_pkg;

  localparam int FN_W = 3;

  localparam logic [FN_W-1:0] FN_AND   = 3'd0;
  localparam logic [FN_W-1:0] FN_OR    = 3'd1;
  localparam logic [FN_W-1:0] FN_XOR   = 3'd2;
  localparam logic [FN_W-1:0] FN_NAND  = 3'd3;
  localparam logic [FN_W-1:0] FN_NOR   = 3'd4;
  localparam logic [FN_W-1:0] FN_XNOR  = 3'd5;
  localparam logic [FN_W-1:0] FN_ANDNB = 3'd6;
  localparam logic [FN_W-1:0] FN_PASSA = 3'd7;

endpackage

// File: rtl/programmable_gate_fn.sv
// Combinational bitwise function unit: o_y = f(i_fn, i_a, i_b).
module programmable_gate_fn
  import programmable_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [FN_W-1:0]  i_fn,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  // Select the bitwise operation for the current function code.
  always_comb begin
    o_y = '0;
    case (i_fn)
      FN_AND:   o_y = i_a & i_b;
      FN_OR:    o_y = i_a | i_b;
      FN_XOR:   o_y = i_a ^ i_b;
      FN_NAND:  o_y = ~(i_a & i_b);
      FN_NOR:   o_y = ~(i_a | i_b);
      FN_XNOR:  o_y = ~(i_a ^ i_b);
      FN_ANDNB: o_y = i_a & ~i_b;
      FN_PASSA: o_y = i_a;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/programmable_gate_pipe.sv
// One-stage valid/ready pipeline around the programmable gate, with config
// register, optional accumulator feedback and an accepted-transfer counter.
module programmable_gate_pipe
  import programmable_gate_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CNT_W    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [FN_W-1:0]  i_cfg_fn,
  input  logic             i_cfg_acc,
  input  logic             i_acc_clr,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_y,
  output logic [CNT_W-1:0] o_xfer_cnt
);

  logic [FN_W-1:0]  r_fn;
  logic             r_acc_mode;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_result;

  // Stage frees up when empty or when the consumer drains it this cycle.
  assign w_in_ready = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && w_in_ready;

  // A clear coincident with an accept must feed ACC_INIT, not the stale accumulator.
  assign w_opb = !r_acc_mode ? i_b : (i_acc_clr ? ACC_INIT : r_acc);

  programmable_gate_fn #(.WIDTH(WIDTH)) u_fn (
    .i_fn (r_fn),
    .i_a  (i_a),
    .i_b  (w_opb),
    .o_y  (w_result)
  );

  // Config register; an accept in the same cycle still sees the old value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fn       <= FN_AND;
      r_acc_mode <= 1'b0;
    end else if (i_cfg_we) begin
      r_fn       <= i_cfg_fn;
      r_acc_mode <= i_cfg_acc;
    end
  end

  // Accumulator: tracks results in accumulate mode, reloaded by clear otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc <= ACC_INIT;
    end else if (w_accept && r_acc_mode) begin
      r_acc <= w_result;
    end else if (i_acc_clr) begin
      r_acc <= ACC_INIT;
    end
  end

  // Output pipe register; y holds its last value when the stage empties.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_result;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accepted-transfer counter, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_y         = r_y;
  assign o_xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_programmable_gate_pipe.sv
// Scoreboard bench for programmable_gate_pipe (WIDTH=8, CNT_W=2).
module tb_programmable_gate_pipe;
  import programmable_gate_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [FN_W-1:0]  cfg_fn;
  logic             cfg_acc;
  logic             acc_clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_push  = 0;
  logic [WIDTH-1:0] exp_q[$];

  programmable_gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_INIT('0)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_we    (cfg_we),
    .i_cfg_fn    (cfg_fn),
    .i_cfg_acc   (cfg_acc),
    .i_acc_clr   (acc_clr),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_y         (y),
    .o_xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", y);
        end else begin
          check("y", {24'd0, y}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ve);
    int k;
    in_valid = 1'b1;
    a = va;
    b = vb;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      k++;
      if (k > 20) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1");
        break;
      end
    end
    exp_q.push_back(ve);
    n_push++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [FN_W-1:0] fn, input logic acc);
    cfg_we  = 1'b1;
    cfg_fn  = fn;
    cfg_acc = acc;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  logic [7:0] sweep_exp [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_fn = '0; cfg_acc = 1'b0; acc_clr = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_xfer_cnt", {30'd0, xfer_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Function sweep
    for (int k = 0; k < 8; k++) begin
      set_cfg(FN_W'(k), 1'b0);
      send(8'hF0, 8'hCC, sweep_exp[k]);
    end

    // Backpressure with XOR
    set_cfg(FN_XOR, 1'b0);
    send(8'h01, 8'h00, 8'h01);
    send(8'h02, 8'h00, 8'h02);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'h03;
    b = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_y", {24'd0, y}, 32'h02);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'h03, 8'h00, 8'h03);
    repeat (2) @(posedge clk);
    #1;

    // Accumulate
    set_cfg(FN_OR, 1'b1);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(8'h01, 8'h55, 8'h01);
    send(8'h02, 8'h55, 8'h03);
    send(8'h04, 8'h55, 8'h07);
    acc_clr = 1'b1;
    send(8'h08, 8'h55, 8'h08);
    acc_clr = 1'b0;

    // Config write coincident with accept uses old function
    set_cfg(FN_AND, 1'b0);
    cfg_we = 1'b1; cfg_fn = FN_OR; cfg_acc = 1'b0;
    send(8'h0F, 8'hF0, 8'h00);
    cfg_we = 1'b0;
    send(8'h0F, 8'hF0, 8'hFF);
    repeat (2) @(posedge clk);
    #1;

    // Counter wrap at CNT_W=2 and reset mid-transfer
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_cfg(FN_PASSA, 1'b0);
    for (int k = 1; k <= 5; k++) send(8'(k), 8'h00, 8'(k));
    out_ready = 1'b0;
    @(negedge clk);
    check("wrap_xfer_cnt", {30'd0, xfer_cnt}, 32'd1);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_xfer_cnt", {30'd0, xfer_cnt}, 32'd0);
    check("mid_rst_y", {24'd0, y}, 32'd0);
    // The held value was dropped by reset, so it will never be observed.
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      n_push--;
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("output_count", n_out, n_push);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
